// File: rtl/credfc_rr_arb.sv
// credfc_rr_arb
//   Credit-based flow-control sender shared by N_REQ requesters through a
//   round-robin arbiter. It holds one credit counter and grants a requester
//   only while at least one credit is held. The winning flit is registered
//   onto the downstream link one cycle after the handshake.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active low
//   credit_initval credit count loaded in the INIT cycle after reset release
//   req_data       packed requester data, requester i at [i*D_WIDTH +: D_WIDTH]
//   req_valid      per-requester valid
//   req_ready      per-requester ready, one-hot or zero
//   down_data      registered flit data
//   down_id        registered index of the sending requester
//   down_valid     registered single-cycle flit strobe
//   down_credit    one-cycle credit return pulse
//   credit_cnt     credits currently held
//   cred_err       sticky credit-overflow flag
//   busy           credit_cnt below the loaded initial value (flits outstanding)

// Per-requester grant slice. Requester IDX wins when it is eligible and no
// eligible requester lies before it on the cyclic search that begins at
// 'start'. Distances are measured modulo N_REQ from 'start'.
module credfc_rr_slice #(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2,
  parameter int IDX      = 0
) (
  input  logic [N_REQ-1:0]    elig,
  input  logic [ID_WIDTH-1:0] start,
  output logic                gnt
);
  int  my_dist;
  logic blocked;

  always_comb begin
    my_dist = (IDX - int'(start) + N_REQ) % N_REQ;
    blocked = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (elig[j] && (((j - int'(start) + N_REQ) % N_REQ) < my_dist))
        blocked = 1'b1;
    end
    gnt = elig[IDX] & ~blocked;
  end
endmodule

module credfc_rr_arb #(
  parameter int D_WIDTH      = 6,
  parameter int N_REQ        = 4,
  parameter int ID_WIDTH     = 2,
  parameter int CREDIT_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CREDIT_WIDTH-1:0]    credit_initval,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  output logic [D_WIDTH-1:0]         down_data,
  output logic [ID_WIDTH-1:0]        down_id,
  output logic                       down_valid,
  input  logic                       down_credit,
  output logic [CREDIT_WIDTH-1:0]    credit_cnt,
  output logic                       cred_err,
  output logic                       busy
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(N_REQ - 1);

  typedef struct packed {
    logic                vld;
    logic [ID_WIDTH-1:0] id;
    logic [D_WIDTH-1:0]  data;
  } flit_t;

  logic [0:0]              state;
  logic [CREDIT_WIDTH-1:0] cnt;
  logic [CREDIT_WIDTH-1:0] init_reg;
  logic [CREDIT_WIDTH-1:0] cnt_next;
  logic [ID_WIDTH-1:0]     last_grant;
  logic [ID_WIDTH-1:0]     start;
  logic [N_REQ-1:0]        elig;
  logic [N_REQ-1:0]        gnt;
  logic                    send;
  logic                    over;
  logic                    hold;
  logic                    err_q;
  flit_t                   flit_q;
  flit_t                   flit_d;

  // Search begins one past the last winner; reset leaves last_grant at
  // N_REQ-1 so requester 0 is first after every reset.
  assign start = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;

  // No bypass: a credit returned this cycle is not usable until next cycle.
  assign elig = (state == ST_RUN && cnt != '0) ? req_valid : '0;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    credfc_rr_slice #(
      .N_REQ    (N_REQ),
      .ID_WIDTH (ID_WIDTH),
      .IDX      (i)
    ) u_slice (
      .elig  (elig),
      .start (start),
      .gnt   (gnt[i])
    );
  end

  // gnt is a subset of req_valid, so any grant is a transfer.
  assign req_ready = gnt;
  assign send      = |gnt;

  always_comb begin
    flit_d     = '0;
    flit_d.vld = send;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        flit_d.id   = ID_WIDTH'(i);
        flit_d.data = req_data[i*D_WIDTH +: D_WIDTH];
      end
    end
  end

  // A return with nothing outstanding is an overflow. With a nonzero initial
  // value the count holds at init_reg. With a zero initial value the returned
  // credit is still taken (so traffic can proceed) but flagged; only the
  // counter's own maximum forces a hold there to avoid wrapping.
  always_comb begin
    over     = down_credit & ~send & (cnt >= init_reg);
    hold     = over & ((init_reg != '0) | (cnt == '1));
    cnt_next = hold ? cnt
                    : cnt + CREDIT_WIDTH'(down_credit) - CREDIT_WIDTH'(send);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_INIT;
      cnt        <= '0;
      init_reg   <= '0;
      last_grant <= LAST_IDX;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          // Returns arriving in INIT are dropped; the load wins.
          cnt      <= credit_initval;
          init_reg <= credit_initval;
          state    <= ST_RUN;
        end
        default: begin
          cnt <= cnt_next;
          if (over) err_q <= 1'b1;
          if (send) last_grant <= flit_d.id;
        end
      endcase
    end
  end

  // Data/id only move on a transfer; they are meaningful with down_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_q <= '0;
    end else begin
      flit_q.vld <= flit_d.vld;
      if (flit_d.vld) begin
        flit_q.id   <= flit_d.id;
        flit_q.data <= flit_d.data;
      end
    end
  end

  assign down_valid = flit_q.vld;
  assign down_id    = flit_q.id;
  assign down_data  = flit_q.data;
  assign credit_cnt = cnt;
  assign cred_err   = err_q;
  assign busy       = (cnt < init_reg);

endmodule

// File: tb/tb_credfc_rr_arb.sv
module tb_credfc_rr_arb;
  localparam int D_WIDTH      = 6;
  localparam int N_REQ        = 4;
  localparam int ID_WIDTH     = 2;
  localparam int CREDIT_WIDTH = 3;

  logic                     clk;
  logic                     rst;
  logic [CREDIT_WIDTH-1:0]  credit_initval;
  logic [N_REQ*D_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [D_WIDTH-1:0]       down_data;
  logic [ID_WIDTH-1:0]      down_id;
  logic                     down_valid;
  logic                     down_credit;
  logic [CREDIT_WIDTH-1:0]  credit_cnt;
  logic                     cred_err;
  logic                     busy;

  int n_chk  = 0;
  int n_pass = 0;

  credfc_rr_arb #(
    .D_WIDTH      (D_WIDTH),
    .N_REQ        (N_REQ),
    .ID_WIDTH     (ID_WIDTH),
    .CREDIT_WIDTH (CREDIT_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .credit_initval (credit_initval),
    .req_data       (req_data),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .down_data      (down_data),
    .down_id        (down_id),
    .down_valid     (down_valid),
    .down_credit    (down_credit),
    .credit_cnt     (credit_cnt),
    .cred_err       (cred_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready"}, 32'(req_ready), 32'h0);
    chk({tag, ".dvalid"}, 32'(down_valid), 32'h0);
    chk({tag, ".ddata"}, 32'(down_data), 32'h0);
    chk({tag, ".did"}, 32'(down_id), 32'h0);
    chk({tag, ".cnt"}, 32'(credit_cnt), 32'h0);
    chk({tag, ".err"}, 32'(cred_err), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
  endtask

  // Releases reset away from the edge, checks the INIT cycle grants nothing,
  // then advances through INIT.
  task automatic release_rst(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk({tag, ".init_ready"}, 32'(req_ready), 32'h0);
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    credit_initval = 3'd3;
    req_data       = {6'd16, 6'd11, 6'd6, 6'd1};
    req_valid      = '0;
    down_credit    = 1'b0;
    #3 rst = 1'b0;
    #4;
    chk_all_zero("rst0");

    // ---- initval 3, all valid, no returns: grants 0,1,2 then stall
    req_valid = 4'b1111;
    release_rst("t1");
    chk("t1.cnt_load", 32'(credit_cnt), 32'd3);
    chk("t1.busy_full", 32'(busy), 32'd0);
    chk("t1.ready0", 32'(req_ready), 32'b0001);
    tick();
    chk("t1.v0", 32'(down_valid), 32'd1);
    chk("t1.id0", 32'(down_id), 32'd0);
    chk("t1.data0", 32'(down_data), 32'd1);
    chk("t1.ready1", 32'(req_ready), 32'b0010);
    chk("t1.cnt2", 32'(credit_cnt), 32'd2);
    tick();
    chk("t1.id1", 32'(down_id), 32'd1);
    chk("t1.ready2", 32'(req_ready), 32'b0100);
    tick();
    chk("t1.id2", 32'(down_id), 32'd2);
    chk("t1.data2", 32'(down_data), 32'd11);
    chk("t1.cnt0", 32'(credit_cnt), 32'd0);
    chk("t1.ready_none", 32'(req_ready), 32'h0);
    chk("t1.busy", 32'(busy), 32'd1);
    tick();
    chk("t1.v_idle", 32'(down_valid), 32'd0);
    chk("t1.ready_stall", 32'(req_ready), 32'h0);

    // ---- single return at zero: no grant in the return cycle
    down_credit = 1'b1;
    #1;
    chk("t3.no_bypass", 32'(req_ready), 32'h0);
    tick();
    down_credit = 1'b0;
    chk("t3.cnt1", 32'(credit_cnt), 32'd1);
    chk("t3.ready3", 32'(req_ready), 32'b1000);
    tick();
    chk("t3.v", 32'(down_valid), 32'd1);
    chk("t3.id3", 32'(down_id), 32'd3);
    chk("t3.data3", 32'(down_data), 32'd16);
    chk("t3.cnt0", 32'(credit_cnt), 32'd0);
    chk("t3.ready_none", 32'(req_ready), 32'h0);
    tick();
    chk("t3.one_flit", 32'(down_valid), 32'd0);

    // ---- build cnt=1 with a flit in flight, then async reset mid-cycle
    down_credit = 1'b1;
    tick();
    chk("t5.cnt1", 32'(credit_cnt), 32'd1);
    chk("t5.ready_wrap", 32'(req_ready), 32'b0001);
    tick();
    down_credit = 1'b0;
    chk("t5.send_ret_cnt", 32'(credit_cnt), 32'd1);
    chk("t5.v_inflight", 32'(down_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("t5.async");
    tick();
    release_rst("t5");
    chk("t5.reload", 32'(credit_cnt), 32'd3);
    chk("t5.prio0", 32'(req_ready), 32'b0001);

    // ---- requesters 1,3 with a return every cycle after the first send
    req_valid = 4'b1010;
    #1;
    chk("t2.ready_first", 32'(req_ready), 32'b0010);
    tick();
    chk("t2.id_first", 32'(down_id), 32'd1);
    chk("t2.cnt_first", 32'(credit_cnt), 32'd2);
    down_credit = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2.v", 32'(down_valid), 32'd1);
      chk("t2.id", 32'(down_id), (k % 2 == 0) ? 32'd3 : 32'd1);
      chk("t2.cnt", 32'(credit_cnt), 32'd2);
    end
    down_credit = 1'b0;
    req_valid   = '0;

    // ---- overflow with initval 2
    rst = 1'b0;
    credit_initval = 3'd2;
    tick();
    release_rst("t4");
    chk("t4.cnt_load", 32'(credit_cnt), 32'd2);
    down_credit = 1'b1;
    tick();
    down_credit = 1'b0;
    chk("t4.cnt_hold", 32'(credit_cnt), 32'd2);
    chk("t4.err", 32'(cred_err), 32'd1);
    chk("t4.busy", 32'(busy), 32'd0);
    tick(); tick(); tick();
    chk("t4.err_sticky", 32'(cred_err), 32'd1);
    chk("t4.cnt_still", 32'(credit_cnt), 32'd2);
    rst = 1'b0;
    #1;
    chk("t4.err_clr", 32'(cred_err), 32'd0);

    // ---- initval 0, all valid: nothing until a return arrives
    credit_initval = 3'd0;
    req_valid      = 4'b1111;
    tick();
    release_rst("t6");
    for (int k = 0; k < 10; k++) begin
      chk("t6.no_ready", 32'(req_ready), 32'h0);
      tick();
    end
    chk("t6.cnt0", 32'(credit_cnt), 32'd0);
    chk("t6.err0", 32'(cred_err), 32'd0);
    down_credit = 1'b1;
    #1;
    chk("t6.no_bypass", 32'(req_ready), 32'h0);
    tick();
    down_credit = 1'b0;
    chk("t6.err", 32'(cred_err), 32'd1);
    chk("t6.cnt1", 32'(credit_cnt), 32'd1);
    chk("t6.ready0", 32'(req_ready), 32'b0001);
    tick();
    chk("t6.v", 32'(down_valid), 32'd1);
    chk("t6.id", 32'(down_id), 32'd0);
    chk("t6.cnt_after", 32'(credit_cnt), 32'd0);
    chk("t6.ready_none", 32'(req_ready), 32'h0);
    tick();
    chk("t6.one_flit", 32'(down_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
